// File: rtl/gol_window_scanner.sv
// Raster-to-3x3 window front end for the game-of-life cell evaluators.
// One pushed bit per accepted cell. Each push with p >= WIDTH+1 registers the bordered window of cell p-WIDTH-1.
module gol_window_scanner #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_cell,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_mid,
    output logic [7:0]                out_nbr,
    output logic [$clog2(HEIGHT)-1:0] out_row,
    output logic [$clog2(WIDTH)-1:0]  out_col,
    output logic                      out_last
);
    localparam int N  = WIDTH * HEIGHT;
    localparam int DL = 2 * WIDTH + 2;
    localparam int PW = $clog2(N + WIDTH + 1);
    localparam int RW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t          state_q;
    logic [PW-1:0]   p_q;
    logic [DL-1:0]   dl_q;
    logic [RW-1:0]   win_row_q;
    logic [CW-1:0]   win_col_q;
    logic            out_valid_q;
    logic            out_mid_q;
    logic [7:0]      out_nbr_q;
    logic [RW-1:0]   out_row_q;
    logic [CW-1:0]   out_col_q;
    logic            out_last_q;

    logic            push_en;
    logic            push_bit;
    logic            emit;
    logic [DL:0]     span;
    logic            at_top, at_bot, at_left, at_right;
    logic [7:0]      nbr_raw;
    logic [7:0]      nbr_d;

    assign push_en  = (!out_valid_q || out_ready) &&
                      ((state_q == RUN && in_valid) || state_q == FLUSH);
    assign push_bit = (state_q == RUN) ? in_cell : 1'b0;
    assign emit     = push_en && (p_q >= PW'(WIDTH + 1));

    // Incoming bit plus the stored line form the 2*WIDTH+3 span; span[k] is the cell pushed k pushes ago.
    assign span = {dl_q, push_bit};

    assign at_top   = (win_row_q == '0);
    assign at_bot   = (win_row_q == RW'(HEIGHT - 1));
    assign at_left  = (win_col_q == '0);
    assign at_right = (win_col_q == CW'(WIDTH - 1));

    assign nbr_raw = {span[0], span[1], span[2], span[WIDTH], span[WIDTH+2],
                      span[2*WIDTH], span[2*WIDTH+1], span[2*WIDTH+2]};

    always_comb begin
        nbr_d = nbr_raw;
        if (at_top)   nbr_d = nbr_d & 8'b1111_1000;
        if (at_bot)   nbr_d = nbr_d & 8'b0001_1111;
        if (at_left)  nbr_d = nbr_d & 8'b1101_0110;
        if (at_right) nbr_d = nbr_d & 8'b0110_1011;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            p_q         <= '0;
            dl_q        <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            out_valid_q <= 1'b0;
            out_mid_q   <= 1'b0;
            out_nbr_q   <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (push_en) begin
                dl_q <= span[DL-1:0];
                if (state_q == RUN) begin
                    if (p_q == PW'(N - 1)) state_q <= FLUSH;
                    p_q <= p_q + 1'b1;
                end else if (p_q == PW'(N + WIDTH)) begin
                    state_q <= RUN;
                    p_q     <= '0;
                end else begin
                    p_q <= p_q + 1'b1;
                end
            end
            if (emit) begin
                out_valid_q <= 1'b1;
                out_mid_q   <= span[WIDTH+1];
                out_nbr_q   <= nbr_d;
                out_row_q   <= win_row_q;
                out_col_q   <= win_col_q;
                out_last_q  <= at_bot && at_right;
                if (at_right) begin
                    win_col_q <= '0;
                    win_row_q <= at_bot ? '0 : win_row_q + 1'b1;
                end else begin
                    win_col_q <= win_col_q + 1'b1;
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
    assign out_valid = out_valid_q;
    assign out_mid   = out_mid_q;
    assign out_nbr   = out_nbr_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_last  = out_last_q;
endmodule

// File: tb/tb_gol_window_scanner.sv
// Directed bench for gol_window_scanner on a 4x3 board.
// Windows are captured on handshakes and compared against a 2-D board neighbourhood model and hand values.
module tb_gol_window_scanner;
    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_cell;
    logic       out_valid;
    logic       out_ready;
    logic       out_mid;
    logic [7:0] out_nbr;
    logic [1:0] out_row;
    logic [1:0] out_col;
    logic       out_last;

    gol_window_scanner #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_cell(in_cell),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mid(out_mid), .out_nbr(out_nbr),
        .out_row(out_row), .out_col(out_col), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic feed [0:47];
    int feed_len = 0;
    int feed_idx = 0;
    logic bp_arm = 1'b0;
    int cap_row[$], cap_col[$], cap_mid[$], cap_nbr[$], cap_last[$];

    task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_nbr(input logic [11:0] b, input int r, input int c);
        int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
        int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
        logic [7:0] n = 8'h00;
        for (int k = 0; k < 8; k++) begin
            int rr = r + dr[k];
            int cc = c + dc[k];
            if (rr >= 0 && rr < H && cc >= 0 && cc < W) n[k] = b[rr*W + cc];
        end
        return n;
    endfunction

    task automatic update_inputs();
        in_valid = (feed_idx < feed_len);
        in_cell  = in_valid ? feed[feed_idx] : 1'b0;
    endtask

    task automatic backpressure();
        logic [13:0] snap;
        out_ready = 1'b0;
        snap = {out_mid, out_nbr, out_row, out_col, out_last};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", i, 32'(out_valid), 32'd1);
            check("bp_hold", i, 32'({out_mid, out_nbr, out_row, out_col, out_last}), 32'(snap));
            check("bp_in_ready", i, 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        bp_arm = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        if (in_valid && in_ready) feed_idx++;
        if (out_valid && out_ready) begin
            cap_row.push_back(int'(out_row));
            cap_col.push_back(int'(out_col));
            cap_mid.push_back(int'(out_mid));
            cap_nbr.push_back(int'(out_nbr));
            cap_last.push_back(int'(out_last));
        end
        @(posedge clk);
        #1;
        update_inputs();
        if (bp_arm && out_valid && out_row == 2'd1 && out_col == 2'd2) backpressure();
    endtask

    task automatic clear_caps();
        cap_row.delete(); cap_col.delete(); cap_mid.delete(); cap_nbr.delete(); cap_last.delete();
    endtask

    task automatic start_feed();
        feed_len = 0;
        feed_idx = 0;
        clear_caps();
    endtask

    task automatic feed_board(input logic [11:0] b);
        for (int i = 0; i < N; i++) begin
            feed[feed_len] = b[i];
            feed_len++;
        end
        update_inputs();
    endtask

    task automatic run(input int nwin);
        int budget = 0;
        while (cap_row.size() < nwin && budget < 300) begin
            tick();
            budget++;
        end
        repeat (12) tick();
        check("win_count", nwin, 32'(cap_row.size()), 32'(nwin));
    endtask

    task automatic check_frame(input logic [11:0] b, input int base);
        for (int q = 0; q < N; q++) begin
            check("row", base + q, 32'(cap_row[base+q]), 32'(q / W));
            check("col", base + q, 32'(cap_col[base+q]), 32'(q % W));
            check("mid", base + q, 32'(cap_mid[base+q]), 32'(b[q]));
            check("nbr", base + q, 32'(cap_nbr[base+q]), 32'(model_nbr(b, q / W, q % W)));
            check("last", base + q, 32'(cap_last[base+q]), 32'(q == N - 1));
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_cell = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", 0, 32'(out_valid), 32'd0);
        check("rst_out_mid", 0, 32'(out_mid), 32'd0);
        check("rst_out_nbr", 0, 32'(out_nbr), 32'd0);
        check("rst_out_row", 0, 32'(out_row), 32'd0);
        check("rst_out_col", 0, 32'(out_col), 32'd0);
        check("rst_out_last", 0, 32'(out_last), 32'd0);
        check("rst_in_ready", 0, 32'(in_ready), 32'd1);

        // Single live cell at (1,1)
        start_feed();
        feed_board(12'h020);
        run(N);
        check_frame(12'h020, 0);
        check("s1_nbr_00", 0, 32'(cap_nbr[0]), 32'h80);
        check("s1_mid_00", 0, 32'(cap_mid[0]), 32'd0);
        check("s1_mid_11", 5, 32'(cap_mid[5]), 32'd1);
        check("s1_nbr_11", 5, 32'(cap_nbr[5]), 32'h00);
        check("s1_nbr_22", 10, 32'(cap_nbr[10]), 32'h01);

        // All-ones board
        start_feed();
        feed_board(12'hFFF);
        run(N);
        check_frame(12'hFFF, 0);
        check("s2_nbr_00", 0, 32'(cap_nbr[0]), 32'hD0);
        check("s2_nbr_11", 5, 32'(cap_nbr[5]), 32'hFF);
        check("s2_nbr_23", 11, 32'(cap_nbr[11]), 32'h0B);
        check("s2_last_23", 11, 32'(cap_last[11]), 32'd1);
        check("s2_nbr_13", 7, 32'(cap_nbr[7]), 32'h6B);

        // Live cell only at (0,3): no wrap into (1,0)
        start_feed();
        feed_board(12'h008);
        run(N);
        check_frame(12'h008, 0);
        check("s3_nbr_10", 4, 32'(cap_nbr[4]), 32'h00);
        check("s3_nbr_02", 2, 32'(cap_nbr[2]), 32'h10);
        check("s3_nbr_12", 6, 32'(cap_nbr[6]), 32'h04);

        // Backpressure at window (1,2)
        start_feed();
        bp_arm = 1'b1;
        feed_board(12'h020);
        run(N);
        check("bp_taken", 0, 32'(bp_arm), 32'd0);
        check_frame(12'h020, 0);

        // Back-to-back frames: all ones then all zeros
        start_feed();
        feed_board(12'hFFF);
        feed_board(12'h000);
        run(2 * N);
        check_frame(12'hFFF, 0);
        check_frame(12'h000, N);

        // Reset after 7 cells, then a fresh single-cell frame
        start_feed();
        feed_board(12'hFFF);
        for (int i = 0; i < 100 && feed_idx < 7; i++) tick();
        check("s6_fed", 0, 32'(feed_idx), 32'd7);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("s6_out_valid", 0, 32'(out_valid), 32'd0);
        check("s6_in_ready", 0, 32'(in_ready), 32'd1);
        start_feed();
        feed_board(12'h020);
        run(N);
        check_frame(12'h020, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
